// File: rtl/flght_seq_if.sv
// Command/status bundle between the front end, the flight sequencer and the flight controller.
interface flght_seq_if;
  logic       strt_cal;
  logic       motors_off;
  logic       cmd_rdy;
  logic       cal_done;
  logic [8:0] thrst_cmd;
  logic       inertial_cal;
  logic [8:0] thrst;
  logic       mtrs_en;
  logic       cal_cmplt;
  logic       fault;
  logic [2:0] state;

  modport master (
    output strt_cal, motors_off, cmd_rdy, cal_done, thrst_cmd,
    input  inertial_cal, thrst, mtrs_en, cal_cmplt, fault, state
  );

  modport slave (
    input  strt_cal, motors_off, cmd_rdy, cal_done, thrst_cmd,
    output inertial_cal, thrst, mtrs_en, cal_cmplt, fault, state
  );
endinterface

// File: rtl/flght_seq.sv
// Flight mode sequencer: calibration with timeout, slewed spin-up/landing,
// and a forced descent when the command link goes quiet. All outputs registered.
module flght_seq #(
  parameter int CAL_TMO  = 1_000_000,
  parameter int RAMP_DIV = 2048,
  parameter int WDOG_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  flght_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAL   = 3'd1,
    RAMP  = 3'd2,
    RUN   = 3'd3,
    DSCND = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam int CW = (CAL_TMO  > 1) ? $clog2(CAL_TMO)  : 1;
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [CW-1:0] CAL_LAST = CW'(CAL_TMO - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WDOG_CYC - 1);

  state_t        r_state, w_nxt;
  logic [8:0]    r_thrst, w_thrst;
  logic          r_fault, w_fault;
  logic          r_cal_cmplt, w_cal_cmplt;
  logic          r_inertial_cal, r_mtrs_en;
  logic [CW-1:0] r_cal_cnt, w_cal_cnt;
  logic [DW-1:0] r_div, w_div;
  logic [WW-1:0] r_wd, w_wd;
  logic          w_step, w_wd_exp;

  assign w_step = (r_div == DIV_LAST);

  always_comb begin
    w_nxt       = r_state;
    w_thrst     = r_thrst;
    w_fault     = r_fault;
    w_cal_cmplt = 1'b0;
    w_cal_cnt   = '0;
    w_div       = '0;
    w_wd        = '0;
    w_wd_exp    = 1'b0;

    case (r_state)
      IDLE: begin
        w_thrst = '0;
        if (bus.strt_cal && !bus.motors_off) w_nxt = CAL;
      end

      CAL: begin
        w_thrst = '0;
        if (bus.motors_off) begin
          w_nxt = IDLE;
        end else if (bus.cal_done) begin
          w_nxt       = RAMP;
          w_cal_cmplt = 1'b1;
        end else if (r_cal_cnt == CAL_LAST) begin
          w_nxt   = FAULT;
          w_fault = 1'b1;
        end else begin
          w_cal_cnt = r_cal_cnt + CW'(1);
        end
      end

      RAMP, RUN: begin
        // cmd_rdy on the terminal count rescues the link; counter holds at terminal otherwise
        w_wd_exp = !bus.cmd_rdy && (r_wd == WD_LAST);
        if (bus.cmd_rdy)   w_wd = '0;
        else if (w_wd_exp) w_wd = r_wd;
        else               w_wd = r_wd + WW'(1);

        if (bus.motors_off) begin
          w_nxt = DSCND;
        end else if (w_wd_exp) begin
          w_nxt   = DSCND;
          w_fault = 1'b1;
        end else if (r_state == RUN) begin
          w_thrst = bus.thrst_cmd;
        end else if (r_thrst == bus.thrst_cmd) begin
          w_nxt = RUN;
        end else if (w_step) begin
          w_thrst = (r_thrst < bus.thrst_cmd) ? r_thrst + 9'd1 : r_thrst - 9'd1;
        end else begin
          w_div = r_div + DW'(1);
        end
      end

      DSCND: begin
        if (r_thrst == '0)  w_nxt   = r_fault ? FAULT : IDLE;
        else if (w_step)    w_thrst = r_thrst - 9'd1;
        else                w_div   = r_div + DW'(1);
      end

      FAULT: begin
        w_thrst = '0;
        if (bus.strt_cal) begin
          w_nxt   = CAL;
          w_fault = 1'b0;
        end
      end

      default: begin
        w_nxt   = IDLE;
        w_thrst = '0;
      end
    endcase

    if (w_nxt != r_state) w_div = '0;
    if (!(w_nxt inside {RAMP, RUN})) w_wd = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_thrst        <= '0;
      r_fault        <= 1'b0;
      r_cal_cmplt    <= 1'b0;
      r_inertial_cal <= 1'b0;
      r_mtrs_en      <= 1'b0;
      r_cal_cnt      <= '0;
      r_div          <= '0;
      r_wd           <= '0;
    end else begin
      r_state        <= w_nxt;
      r_thrst        <= w_thrst;
      r_fault        <= w_fault;
      r_cal_cmplt    <= w_cal_cmplt;
      r_inertial_cal <= (w_nxt == CAL);
      r_mtrs_en      <= (w_nxt inside {CAL, RAMP, RUN, DSCND});
      r_cal_cnt      <= w_cal_cnt;
      r_div          <= w_div;
      r_wd           <= w_wd;
    end
  end

  assign bus.inertial_cal = r_inertial_cal;
  assign bus.thrst        = r_thrst;
  assign bus.mtrs_en      = r_mtrs_en;
  assign bus.cal_cmplt    = r_cal_cmplt;
  assign bus.fault        = r_fault;
  assign bus.state        = r_state;

endmodule

// File: doc/flght_seq.md
# flght_seq

Flight sequencer that owns the operating mode of the quadcopter datapath. It sits between the command/config front end and the flight controller and drives the controller's `inertial_cal` input and its thrust input. It also drives the motor-enable gate to the ESC interface. It runs calibration with a timeout, slews thrust on spin-up and landing, and forces a controlled descent when the command link goes silent.

## Interface
- CAL_TMO, 1_000_000 — cycles allowed in CAL before declaring a calibration fault
- RAMP_DIV, 2048 — cycles per 1-LSB thrust step while slewing (≥2)
- WDOG_CYC, 2_000_000 — cycles without `cmd_rdy` before a link-loss descent
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- strt_cal  in  1  one-cycle request to calibrate/arm (from cmd_cfg)
- motors_off  in  1  level; command to stop motors
- cmd_rdy  in  1  one-cycle pulse per received command; kicks watchdog
- cal_done  in  1  one-cycle pulse from inertial interface, calibration finished
- thrst_cmd  in  9  commanded thrust, unsigned
- inertial_cal  out  1  high only in CAL; flight controller runs CAL_SPEED
- thrst  out  9  sequenced thrust to flight controller, unsigned
- mtrs_en  out  1  motor enable to ESC interface
- cal_cmplt  out  1  one-cycle pulse on successful calibration
- fault  out  1  sticky fault flag
- state  out  3  current state encoding (debug)

## Operation
- States/encoding: IDLE=0, CAL=1, RAMP=2, RUN=3, DSCND=4, FAULT=5. Codes 6 and 7 go to IDLE.
- IDLE: mtrs_en=0, thrst=0. `strt_cal & !motors_off` → CAL.
- CAL: inertial_cal=1, mtrs_en=1, thrst=0. Cal counter cleared on entry.
  - `motors_off` → IDLE.
  - Else `cal_done` → RAMP, with a cal_cmplt pulse.
  - Else counter == CAL_TMO-1 → FAULT.
  - cal_done beats timeout in the same cycle.
- RAMP: mtrs_en=1. Every RAMP_DIV cycles, thrst steps ±1 toward thrst_cmd, in either direction. When thrst == thrst_cmd → RUN, checked every cycle, so thrst_cmd=0 at entry gives RUN next cycle.
- RUN: mtrs_en=1. thrst ← thrst_cmd every cycle, no slew.
- RAMP/RUN exits:
  - `motors_off` → DSCND.
  - Watchdog expiry → DSCND with fault set.
  - motors_off beats watchdog.
- DSCND: mtrs_en=1. thrst decrements 1 per RAMP_DIV cycles, never below 0, ignoring thrst_cmd. At thrst==0 → FAULT if fault set, else IDLE. motors_off has no effect here.
- FAULT: mtrs_en=0, thrst=0, fault=1. `strt_cal` clears fault → CAL. motors_off is ignored.
- Watchdog:
  - Counter runs only in RAMP/RUN.
  - Cleared on cmd_rdy and on entry to RAMP.
  - Expiry when counter == WDOG_CYC-1 without cmd_rdy that cycle; cmd_rdy beats expiry.
- Slew divider:
  - Cleared on every state change.
  - Steps when divider == RAMP_DIV-1, then wraps to 0.
  - First step occurs RAMP_DIV cycles after state entry.
- Counter widths: $clog2 of the respective parameter. No counter ever wraps past its terminal value.
- fault is set on cal timeout or watchdog expiry. It is cleared only by rst or by strt_cal in FAULT.

## Timing
- All outputs registered (Moore). They change the cycle after the causing input is sampled.
- Reset values: state=IDLE, inertial_cal=0, thrst=0, mtrs_en=0, cal_cmplt=0, fault=0, all counters 0.
- Reset mid-operation: outputs return to reset values asynchronously, with no descent.
- strt_cal sampled at edge N → inertial_cal=1, state=1 after edge N.
- cal_done at edge N → cal_cmplt=1 for exactly the cycle after edge N; inertial_cal=0 from that cycle.
- RUN thrust latency: 1 cycle from thrst_cmd to thrst.
- strt_cal outside IDLE/FAULT is ignored. cal_done outside CAL is ignored.

## Test plan
Bench overrides: CAL_TMO=100, RAMP_DIV=4, WDOG_CYC=50; cmd_rdy pulsed every 20 cycles unless stated.
- Nominal arm: strt_cal, then cal_done 30 cycles later, thrst_cmd=3.
  - inertial_cal high 30 cycles, then one cal_cmplt pulse.
  - thrst goes 1, 2, 3 at 4-cycle spacing, then state=RUN.
  - Later, thrst_cmd=200 → thrst=200 one cycle later.
- Cal timeout: strt_cal, no cal_done → after 100 cycles state=FAULT, fault=1, mtrs_en=0. Then strt_cal → CAL, fault=0.
- Landing: in RUN with thrst=5, assert motors_off.
  - state=DSCND; thrst 5→0 in 20 cycles, 4 per step.
  - Then IDLE, mtrs_en=0, fault=0.
- Link loss: in RUN with thrst=2, stop cmd_rdy.
  - After 50 cycles, DSCND with fault=1.
  - thrst reaches 0 after 8 cycles, then FAULT.
  - A cmd_rdy on the terminal cycle instead keeps RUN.
- Races:
  - cal_done and timeout in the same cycle → RAMP.
  - motors_off and strt_cal together in IDLE → stay IDLE.
  - rst asserted mid-RAMP with thrst=2 → thrst=0 and mtrs_en=0 immediately.
